trivium_wide: RTL and testbench
===============================

# trivium_wide

Parametrised Trivium keystream generator. It produces W keystream bits per clock by unrolling W cipher rounds per cycle. Initialisation is a multi-cycle sequential warm-up, and output uses a valid/ready handshake. It replaces the single-bit, one-shot-initialisation generator as the keystream source feeding the stream-cipher XOR datapath.

## Interface
Parameters:
- W, default 8: keystream bits per cycle. Legal values are 1, 2, 4, 8, 16, 32, 64. Values above 64 are illegal because they would break tap independence; elaboration `$error`s on them.
- INIT_ROUNDS, default 1152: warm-up rounds. Must be a multiple of W; `$error` otherwise. N = INIT_ROUNDS/W warm-up cycles.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- key, input, 80: cipher key, bits [80:1]. Sampled only on the accepting start edge.
- iv, input, 80: initialisation vector, bits [80:1]. Sampled only on the accepting start edge.
- start, input, 1: load key/iv and begin warm-up. Accepted in any state.
- busy, output, 1: high while in INIT.
- ks_valid, output, 1: high in RUN; ks_data is valid.
- ks_ready, input, 1: consumer accepts ks_data this cycle.
- ks_data, output, W: keystream word. Bit 0 is the earliest bit in time.

## Operation
- State registers are A[93:1], B[84:1] and C[111:1].
- One round is defined as:
  - t1 = A[66]^A[93]; t2 = B[69]^B[84]; t3 = C[66]^C[111]; z = t1^t2^t3.
  - A <= {A[92:1], t3^(C[109]&C[110])^A[69]}.
  - B <= {B[83:1], t1^(A[91]&A[92])^B[78]}.
  - C <= {C[110:1], t2^(B[82]&B[83])^C[87]}.
- All three feedbacks use pre-round values.
- Unrolled step: W rounds chained combinationally. ks_data[j] = z of round j in the chain, so ks_data[0] = z of the current register state.
- FSM states are IDLE, INIT and RUN. Encoding is free; the state is not exported.
- Load (start=1 at an edge, any state):
  - A <= {13'b0, key}; B <= {4'b0, iv}; C <= {3'b111, 108'b0}.
  - cnt <= 0; state <= INIT.
- INIT: each edge applies one W-round step and increments cnt. On the edge where cnt == N-1, state <= RUN.
- RUN: on an edge with ks_ready=1 and start=0, apply one W-round step (word consumed). With ks_ready=0, registers hold and ks_data is stable.
- IDLE: registers hold; ks_valid=0; ks_ready is ignored.
- cnt width is clog2(N+1). Wrap-around cannot occur because cnt stops at N-1.
- Priority: rst > start > step.
  - start in INIT restarts warm-up from the new key/iv.
  - start in RUN together with ks_ready: start wins, and the word presented that cycle is discarded and not counted as consumed.
- ks_ready in INIT/IDLE has no effect.
- Outputs:
  - busy = (state==INIT).
  - ks_valid = (state==RUN).
  - ks_data is a combinational function of the A/B/C registers only, with no input-to-output combinational path.

## Timing
- Reset (async assert, takes effect immediately):
  - A, B, C = 0; cnt = 0; state = IDLE.
  - busy = 0; ks_valid = 0; ks_data = 0, since all-zero state gives z = 0.
- Latency: start sampled at edge E0. busy is high from after E0. ks_valid rises after edge E0+N, with busy falling at the same edge.
  - W=8: N=144.
  - W=1: N=1152.
  - W=64: N=18.
- Throughput in RUN is one word per cycle while ks_ready is held high.
- rst asserted mid-INIT or mid-RUN returns the block to IDLE with the reset values above. Deassertion is synchronised externally. The first start is honoured on the first edge after release.
- key and iv may change freely after the load edge.

## Test plan
- Reset, then no stimulus: busy=0, ks_valid=0 and ks_data=0 hold for 100 cycles.
- W=8, key=0, iv=0, start pulse at E0:
  - busy=1 for exactly 144 cycles.
  - ks_valid first high after E0+144.
  - The first 128 words, concatenated bit 0 first, equal the first 1024 bits from a W=1 instance given the same stimulus.
- W=8, key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA9876543210FEDC:
  - ks_ready toggles pseudo-randomly.
  - ks_data stays stable while ks_ready=0.
  - The consumed word stream equals the golden model's stream. No word is skipped or duplicated.
- Restart mid-INIT, W=16: start at E0, second start with a different key at E0+30. ks_valid rises after E0+30+72, and the output matches a fresh run of the second key.
- start in RUN with ks_ready=1: the word presented that cycle is dropped. After 144 cycles (W=8), the output restarts from the first word of the new key/iv.
- Reset mid-RUN and mid-INIT: all outputs return to 0 asynchronously before the next edge. A subsequent start behaves identically to a start after power-on reset.

Source files
------------

// File: rtl/trivium_wide.sv
// Trivium keystream generator producing W keystream bits per clock.
// Warm-up runs INIT_ROUNDS rounds over INIT_ROUNDS/W cycles; output uses a valid/ready handshake.
module trivium_wide #(
  parameter int W           = 8,
  parameter int INIT_ROUNDS = 1152
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [79:0]  key,
  input  logic [79:0]  iv,
  input  logic         start,
  output logic         busy,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [W-1:0] ks_data
);

  localparam int N  = INIT_ROUNDS / W;
  localparam int CW = (N < 1) ? 1 : $clog2(N + 1);

  // Rounds more than 64 apart would read taps already overwritten within one step.
  if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
    $error("trivium_wide: W must be one of 1,2,4,8,16,32,64");
  end
  if (INIT_ROUNDS % W != 0) begin : g_bad_init
    $error("trivium_wide: INIT_ROUNDS must be a multiple of W");
  end

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [93:1]   a;
  logic [84:1]   b;
  logic [111:1]  c;
  logic [93:1]   step_a;
  logic [84:1]   step_b;
  logic [111:1]  step_c;
  logic [W-1:0]  z;

  // W chained rounds; each round's feedback uses that round's pre-round values.
  always_comb begin
    logic t1, t2, t3;
    // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
    step_a = a;
    step_b = b;
    step_c = c;
    z      = '0;
    t1     = 1'b0;
    t2     = 1'b0;
    t3     = 1'b0;
    for (int j = 0; j < W; j++) begin
      t1   = step_a[66] ^ step_a[93];
      t2   = step_b[69] ^ step_b[84];
      t3   = step_c[66] ^ step_c[111];
      z[j] = t1 ^ t2 ^ t3;
      step_a = {step_a[92:1], t3 ^ (step_c[109] & step_c[110]) ^ step_a[69]};
      step_b = {step_b[83:1], t1 ^ (step_a[92] & step_a[93]) ^ step_b[78]};
      step_c = {step_c[110:1], t2 ^ (step_b[83] & step_b[84]) ^ step_c[87]};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      c     <= '0;
      cnt   <= '0;
      state <= IDLE;
    end else if (start) begin
      a     <= {13'b0, key};
      b     <= {4'b0, iv};
      c     <= {3'b111, 108'b0};
      cnt   <= '0;
      state <= INIT;
    end else begin
      case (state)
        INIT: begin
          a   <= step_a;
          b   <= step_b;
          c   <= step_c;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= RUN;
        end
        RUN: begin
          if (ks_ready) begin
            a <= step_a;
            b <= step_b;
            c <= step_c;
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign busy     = (state == INIT);
  assign ks_valid = (state == RUN);
  assign ks_data  = z;

endmodule

// File: tb/tb_trivium_wide.sv
// Self-checking bench for trivium_wide: W=8, W=1 and W=16 instances against a
// 288-bit Trivium reference model written in the classic s1..s288 formulation.
module tb_trivium_wide;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start8 = 1'b0, start1 = 1'b0, start16 = 1'b0;
  logic        ready8 = 1'b0, ready1 = 1'b0, ready16 = 1'b0;
  logic [79:0] key8 = '0, iv8 = '0, key1 = '0, iv1 = '0, key16 = '0, iv16 = '0;
  logic        busy8, busy1, busy16, valid8, valid1, valid16;
  logic [7:0]  data8;
  logic [0:0]  data1;
  logic [15:0] data16;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  trivium_wide #(.W(8)) u8 (
    .clk(clk), .rst(rst), .key(key8), .iv(iv8), .start(start8),
    .busy(busy8), .ks_valid(valid8), .ks_ready(ready8), .ks_data(data8));
  trivium_wide #(.W(1)) u1 (
    .clk(clk), .rst(rst), .key(key1), .iv(iv1), .start(start1),
    .busy(busy1), .ks_valid(valid1), .ks_ready(ready1), .ks_data(data1));
  trivium_wide #(.W(16)) u16 (
    .clk(clk), .rst(rst), .key(key16), .iv(iv16), .start(start16),
    .busy(busy16), .ks_valid(valid16), .ks_ready(ready16), .ks_data(data16));

  always #5 clk = ~clk;

  // Reference model: classic 288-bit Trivium state s[1..288].
  bit s [1:288];

  task automatic model_round(output bit z);
    bit t1, t2, t3;
    t1 = s[66] ^ s[93];
    t2 = s[162] ^ s[177];
    t3 = s[243] ^ s[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[91] & s[92]) ^ s[171];
    t2 = t2 ^ (s[175] & s[176]) ^ s[264];
    t3 = t3 ^ (s[286] & s[287]) ^ s[69];
    for (int i = 288; i >= 2; i--) s[i] = s[i-1];
    s[1]   = t3;
    s[94]  = t1;
    s[178] = t2;
  endtask

  task automatic model_load(input logic [79:0] k, input logic [79:0] v);
    bit z;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    for (int i = 0; i < 1152; i++) model_round(z);
  endtask

  task automatic next_word(input int w, output logic [63:0] e);
    bit z;
    e = '0;
    for (int j = 0; j < w; j++) begin
      model_round(z);
      e[j] = z;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] d_data(input int w);
    case (w)
      1:       return 64'(data1);
      8:       return 64'(data8);
      default: return 64'(data16);
    endcase
  endfunction

  function automatic logic [63:0] d_busy(input int w);
    case (w)
      1:       return 64'(busy1);
      8:       return 64'(busy8);
      default: return 64'(busy16);
    endcase
  endfunction

  function automatic logic [63:0] d_valid(input int w);
    case (w)
      1:       return 64'(valid1);
      8:       return 64'(valid8);
      default: return 64'(valid16);
    endcase
  endfunction

  task automatic set_ready(input int w, input logic v);
    case (w)
      1:       ready1 = v;
      8:       ready8 = v;
      default: ready16 = v;
    endcase
  endtask

  // Expects exactly n busy cycles after the start edge, then valid.
  task automatic wait_run(input int w, input int n);
    for (int i = 0; i < n; i++) begin
      check("init_busy", d_busy(w), 64'd1);
      check("init_valid", d_valid(w), 64'd0);
      tick();
    end
    check("run_busy", d_busy(w), 64'd0);
    check("run_valid", d_valid(w), 64'd1);
  endtask

  bit q8 [$];

  task automatic check_words(input int w, input int n, input bit push);
    logic [63:0] e;
    set_ready(w, 1'b1);
    for (int i = 0; i < n; i++) begin
      next_word(w, e);
      check("word", d_data(w), e);
      if (push) for (int j = 0; j < w; j++) q8.push_back(e[j]);
      tick();
    end
    set_ready(w, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy8"}, 64'(busy8), 64'd0);
    check({tag, "_valid8"}, 64'(valid8), 64'd0);
    check({tag, "_data8"}, 64'(data8), 64'd0);
    check({tag, "_busy1"}, 64'(busy1), 64'd0);
    check({tag, "_valid1"}, 64'(valid1), 64'd0);
    check({tag, "_data1"}, 64'(data1), 64'd0);
    check({tag, "_busy16"}, 64'(busy16), 64'd0);
    check({tag, "_valid16"}, 64'(valid16), 64'd0);
    check({tag, "_data16"}, 64'(data16), 64'd0);
  endtask

  initial begin
    logic [63:0] e;
    int          e0;
    int          guard;
    logic        r;

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1 check_all_zero("por");
    tick();
    tick();
    rst = 1'b0;

    // Idle: outputs stay zero, ks_ready ignored.
    for (int i = 0; i < 100; i++) begin
      check("idle_busy", 64'(busy8), 64'd0);
      check("idle_valid", 64'(valid8), 64'd0);
      check("idle_data", 64'(data8), 64'd0);
      ready8 = 1'($urandom_range(0, 1));
      tick();
    end
    ready8 = 1'b0;

    // W=8 and W=1 with zero key/iv, started on the same edge.
    ready1 = 1'b1;
    start8 = 1'b1;
    start1 = 1'b1;
    tick();
    start8 = 1'b0;
    start1 = 1'b0;
    e0 = cyc;
    model_load('0, '0);
    set_ready(8, 1'b1);
    wait_run(8, 144);
    check_words(8, 128, 1'b1);
    guard = 0;
    while (!valid1 && guard < 2000) begin
      tick();
      guard++;
    end
    check("w1_latency", 64'(cyc - e0), 64'd1152);
    check("w1_busy", 64'(busy1), 64'd0);
    for (int i = 0; i < 1024; i++) begin
      check("w1_bit", 64'(data1), 64'(q8[i]));
      tick();
    end

    // Random ks_ready backpressure.
    key8   = 80'h0123456789ABCDEF0123;
    iv8    = 80'hFEDCBA9876543210FEDC;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    key8   = $urandom;
    iv8    = $urandom;
    model_load(80'h0123456789ABCDEF0123, 80'hFEDCBA9876543210FEDC);
    wait_run(8, 144);
    next_word(8, e);
    for (int i = 0; i < 300; i++) begin
      check("rand_valid", 64'(valid8), 64'd1);
      check("rand_word", 64'(data8), e);
      r = 1'($urandom_range(0, 1));
      ready8 = r;
      tick();
      if (r) next_word(8, e);
    end

    // start while RUN with ks_ready high: presented word dropped, new stream begins.
    key8   = 80'h3C3C_A5A5_0F0F_1234_5678;
    iv8    = 80'h0000_1111_2222_3333_4444;
    ready8 = 1'b1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    model_load(80'h3C3C_A5A5_0F0F_1234_5678, 80'h0000_1111_2222_3333_4444);
    wait_run(8, 144);
    check_words(8, 16, 1'b0);

    // W=16 restart mid-INIT with a different key at E0+30.
    key16   = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;
    iv16    = 80'h1357_9BDF_2468_ACE0_1122;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (29) tick();
    check("w16_busy_mid", 64'(busy16), 64'd1);
    key16   = 80'h5555_6666_7777_8888_9999;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    model_load(80'h5555_6666_7777_8888_9999, 80'h1357_9BDF_2468_ACE0_1122);
    wait_run(16, 72);
    check_words(16, 20, 1'b0);

    // Reset with u16 mid-INIT and u8/u1 in RUN; outputs clear before the next edge.
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (10) tick();
    check("pre_rst_busy16", 64'(busy16), 64'd1);
    check("pre_rst_valid8", 64'(valid8), 64'd1);
    #3 rst = 1'b1;
    #1 check_all_zero("async_rst");
    tick();
    rst = 1'b0;
    check_all_zero("post_rst");

    // Start after mid-run reset matches a power-on start.
    key8   = '0;
    iv8    = '0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    model_load('0, '0);
    wait_run(8, 144);
    check_words(8, 16, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
